// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_en_seq.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__invz_en_seq.sv - round-robin break-before-make EN sequencer for N invz drivers
// Optional tenure limit with ABORT: GF180MCU_FD_SC_MCU9T5V0_INVZ_TENURE_EN
module gf180mcu_fd_sc_mcu9t5v0__invz_en_seq #(
    parameter int N    = 4,
    parameter int TA   = 1,
    parameter int MAXT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT,
    output logic [N-1:0] EN,
    output logic         BUSY,
    output logic         ABORT,
    inout  wire          VDD,
    inout  wire          VSS
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    logic [1:0]    state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] winner, owner_inc, cand;
    logic          found;
    logic [2:0]    turn_cnt, turn_n;
    logic [N-1:0]  own_oh_n, gnt_n, en_n;
    logic          unused_supply;

    assign unused_supply = VDD ^ VSS;

`ifdef GF180MCU_FD_SC_MCU9T5V0_INVZ_TENURE_EN
    logic [7:0] tenure, tenure_n;
    logic       abort_n;
`else
    localparam int unused_maxt = MAXT;
    assign ABORT = 1'b0;
`endif

    assign owner_inc = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

    // First set REQ at or above ptr, wrapping, wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && REQ[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        turn_n   = turn_cnt;
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVZ_TENURE_EN
        tenure_n = tenure;
        abort_n  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_n = ST_SETUP;
                    owner_n = winner;
                end
            end
            ST_SETUP: begin
                if (REQ[owner]) begin
                    state_n  = ST_DRIVE;
                    ptr_n    = owner_inc;
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVZ_TENURE_EN
                    tenure_n = '0;
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (!REQ[owner]) begin
                    state_n = ST_TURN;
                    turn_n  = '0;
                end
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVZ_TENURE_EN
                else if (tenure == 8'(MAXT - 1)) begin
                    state_n = ST_TURN;
                    turn_n  = '0;
                    abort_n = 1'b1;
                end else begin
                    tenure_n = tenure + 8'd1;
                end
`endif
            end
            default: begin
                if (turn_cnt == 3'(TA - 1)) begin
                    turn_n = '0;
                    if (found) begin
                        state_n = ST_SETUP;
                        owner_n = winner;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    turn_n = turn_cnt + 3'd1;
                end
            end
        endcase
    end

    // Outputs are computed from the next state so they register on the same edge.
    always_comb begin
        own_oh_n = {{(N - 1){1'b0}}, 1'b1} << owner_n;
        gnt_n    = (state_n == ST_SETUP || state_n == ST_DRIVE) ? own_oh_n : '0;
        en_n     = (state_n == ST_DRIVE) ? own_oh_n : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            turn_cnt <= '0;
            GNT      <= '0;
            EN       <= '0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            turn_cnt <= turn_n;
            GNT      <= gnt_n;
            EN       <= en_n;
            BUSY     <= (state_n != ST_IDLE);
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0_INVZ_TENURE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tenure <= '0;
            ABORT  <= 1'b0;
        end else begin
            tenure <= tenure_n;
            ABORT  <= abort_n;
        end
    end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__invz_en_seq.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__invz_en_seq.sv - scoreboard bench for the invz EN sequencer (TA=1 and TA=3 instances)
module tb_gf180mcu_fd_sc_mcu9t5v0__invz_en_seq;
    logic       clk;
    logic       rst;
    logic [3:0] req1, req3;
    logic [3:0] gnt1, en1, gnt3, en3;
    logic       busy1, abort1, busy3, abort3;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] en;
        logic       busy;
    } exp_t;
    exp_t sb[$];

    gf180mcu_fd_sc_mcu9t5v0__invz_en_seq #(.N(4), .TA(1), .MAXT(16)) u_dut (
        .CLK(clk), .RST(rst), .REQ(req1), .GNT(gnt1), .EN(en1),
        .BUSY(busy1), .ABORT(abort1), .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu9t5v0__invz_en_seq #(.N(4), .TA(3), .MAXT(16)) u_dut_ta3 (
        .CLK(clk), .RST(rst), .REQ(req3), .GNT(gnt3), .EN(en3),
        .BUSY(busy3), .ABORT(abort3), .VDD(vdd), .VSS(vss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Push the expectation with the stimulus, pop it when the edge has produced the output.
    task automatic drive(input bit use3, input logic [3:0] r, input logic [3:0] eg,
                         input logic [3:0] ee, input logic eb);
        exp_t e;
        if (use3) req3 = r;
        else      req1 = r;
        sb.push_back('{gnt: eg, en: ee, busy: eb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (use3) begin
            check("ta3_gnt",   32'(gnt3),   32'(e.gnt));
            check("ta3_en",    32'(en3),    32'(e.en));
            check("ta3_busy",  32'(busy3),  32'(e.busy));
            check("ta3_abort", 32'(abort3), 32'd0);
        end else begin
            check("gnt",   32'(gnt1),   32'(e.gnt));
            check("en",    32'(en1),    32'(e.en));
            check("busy",  32'(busy1),  32'(e.busy));
            check("abort", 32'(abort1), 32'd0);
        end
    endtask

    // Continuous invariants and break-before-make gap monitors.
    int         zrun1, zrun3;
    logic [3:0] prev1, prev3;
    logic       armed1, armed3;
    always @(negedge clk) begin
        if (rst) begin
            zrun1 <= 0; zrun3 <= 0; prev1 <= '0; prev3 <= '0;
            armed1 <= 1'b0; armed3 <= 1'b0;
        end else begin
            check("onehot1",    32'($countones(en1) <= 1), 32'd1);
            check("en_in_gnt1", 32'((en1 & ~gnt1) == 4'd0), 32'd1);
            check("onehot3",    32'($countones(en3) <= 1), 32'd1);
            check("en_in_gnt3", 32'((en3 & ~gnt3) == 4'd0), 32'd1);
            if (en1 != 4'd0 && en1 != prev1 && armed1) check("gap1", 32'(zrun1 >= 2), 32'd1);
            if (en3 != 4'd0 && en3 != prev3 && armed3) check("gap3", 32'(zrun3 >= 4), 32'd1);
            if (en1 != 4'd0) armed1 <= 1'b1;
            if (en3 != 4'd0) armed3 <= 1'b1;
            zrun1 <= (en1 == 4'd0) ? zrun1 + 1 : 0;
            zrun3 <= (en3 == 4'd0) ? zrun3 + 1 : 0;
            prev1 <= en1;
            prev3 <= en3;
        end
    end

    initial begin
        int         len;
        int         ab;
        logic [3:0] oh;
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        req1 = '0;
        req3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",   32'(gnt1),   32'd0);
        check("rst_en",    32'(en1),    32'd0);
        check("rst_busy",  32'(busy1),  32'd0);
        check("rst_abort", 32'(abort1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request: 2-cycle request-to-drive, TA=1 release.
        drive(0, 4'b0100, 4'b0100, 4'b0000, 1);
        drive(0, 4'b0100, 4'b0100, 4'b0100, 1);
        repeat (8) drive(0, 4'b0100, 4'b0100, 4'b0100, 1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0);

        // SETUP cancel leaves ptr at 3, so a full request grants 3 next.
        drive(0, 4'b0010, 4'b0010, 4'b0000, 1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0);
        drive(0, 4'b1111, 4'b1000, 4'b0000, 1);
        drive(0, 4'b1111, 4'b1000, 4'b1000, 1);
        drive(0, 4'b0111, 4'b0000, 4'b0000, 1);
        drive(0, 4'b0100, 4'b0100, 4'b0000, 1);
        drive(0, 4'b0100, 4'b0100, 4'b0100, 1);

        // Asynchronous reset mid-DRIVE of owner 2.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_en",  32'(en1),  32'd0);
        check("async_rst_gnt", 32'(gnt1), 32'd0);
        req1 = 4'b0000;
        @(posedge clk);
        #1;
        check("rst_hold_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin 0,1,2,3,0 with each owner releasing after 3 DRIVE cycles.
        for (int t = 0; t < 5; t++) begin
            oh = 4'b0001 << (t % 4);
            drive(0, 4'b1111, oh, 4'b0000, 1);
            repeat (3) drive(0, 4'b1111, oh, oh, 1);
            drive(0, 4'b1111 & ~oh, 4'b0000, 4'b0000, 1);
        end
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0);

        // TA=3: owner 0 then owner 1 with exactly 4 EN-idle cycles between.
        drive(1, 4'b0011, 4'b0001, 4'b0000, 1);
        drive(1, 4'b0011, 4'b0001, 4'b0001, 1);
        drive(1, 4'b0011, 4'b0001, 4'b0001, 1);
        repeat (3) drive(1, 4'b0010, 4'b0000, 4'b0000, 1);
        drive(1, 4'b0010, 4'b0010, 4'b0000, 1);
        drive(1, 4'b0010, 4'b0010, 4'b0010, 1);
        repeat (3) drive(1, 4'b0000, 4'b0000, 4'b0000, 1);
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Tenure: ptr=1, owner 1 holds while requestor 3 waits.
        drive(0, 4'b1010, 4'b0010, 4'b0000, 1);
        len = 0;
        ab  = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (abort1) ab++;
            if (en1 == 4'b0010) len++;
            else break;
        end
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVZ_TENURE_EN
        check("tenure_len",    32'(len),    32'd16);
        check("tenure_abort",  32'(abort1), 32'd1);
        check("tenure_turn",   32'(gnt1),   32'd0);
        drive(0, 4'b1010, 4'b1000, 4'b0000, 1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0);
`else
        check("hold_len",   32'(len), 32'd1000);
        check("hold_abort", 32'(ab),  32'd0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
